// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, data-memory initiator state type and timeout default
package mips_pkg;

    localparam int ADDRESS_WIDTH  = 32;
    localparam int DATA           = 32;
    localparam int BPI            = 4;   // bytes per instruction/data word
    localparam int TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// rtl/dmem_timeout_ctr.sv - REQ wait counter with expiry compare for the data-memory initiator
//
// Ports:
//   clk, reset (async active-low)
//   clear   - zero the count (transaction accepted, REQ about to be entered)
//   inc     - one more REQ cycle went by without an ack
//   expired - this un-acked REQ cycle is the TIMEOUT_CYCLES-th one
module dmem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [7:0] count;

    // Expiry looks at the count before this cycle's increment, so the
    // abort decision lands on the same edge as the last counted cycle.
    assign expired = inc & (count == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/dmem_initiator.sv
// rtl/dmem_initiator.sv - pipeline-side load/store initiator with req/ack handshake
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a request that has waited
// TIMEOUT_CYCLES REQ cycles without mem_ack (bus_err pulse); otherwise REQ
// waits indefinitely and bus_err is tied 0.
//
// Ports:
//   clk, reset (async active-low)
//   pipe_valid/pipe_load/pipe_store/pipe_addr/pipe_wdata - operation from EX/MEM
//   stall          - freeze upstream (combinational)
//   load_data      - last completed load result, load_valid pulses when new
//   done           - pulse per completed transaction
//   err_misaligned, err_illegal, bus_err - one-cycle error pulses
//   mem_req/mem_we/mem_addr/mem_wdata    - registered request to responder
//   mem_ack/mem_rdata                    - responder completion and read data
module dmem_initiator #(
    parameter int ADDRESS_WIDTH  = mips_pkg::ADDRESS_WIDTH,
    parameter int DATA           = mips_pkg::DATA,
    parameter int TIMEOUT_CYCLES = mips_pkg::TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_valid,
    input  logic                     pipe_load,
    input  logic                     pipe_store,
    input  logic [ADDRESS_WIDTH-1:0] pipe_addr,
    input  logic [DATA-1:0]          pipe_wdata,
    output logic                     stall,
    output logic [DATA-1:0]          load_data,
    output logic                     load_valid,
    output logic                     done,
    output logic                     err_misaligned,
    output logic                     err_illegal,
    output logic                     bus_err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA-1:0]          mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA-1:0]          mem_rdata
);

    import mips_pkg::*;

    localparam int OFS_W = $clog2(BPI);

    dmem_state_t state;

    logic one_kind;
    logic aligned;
    logic accept;
    logic expired;

    assign one_kind = pipe_load ^ pipe_store;
    assign aligned  = (pipe_addr[OFS_W-1:0] == '0);
    assign accept   = (state == IDLE) & pipe_valid & one_kind & aligned;

    // Gated by reset so stall stays low while reset is held.
    assign stall = reset & ((state == REQ) | accept);

`ifdef DMEM_TIMEOUT_EN
    logic bus_err_r;

    assign bus_err = bus_err_r;

    dmem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .inc    ((state == REQ) & ~mem_ack),
        .expired(expired)
    );
`else
    logic unused_timeout;

    assign bus_err        = 1'b0;
    assign expired        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            load_data      <= '0;
            load_valid     <= 1'b0;
            done           <= 1'b0;
            err_misaligned <= 1'b0;
            err_illegal    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_err_r      <= 1'b0;
`endif
        end else begin
            load_valid     <= 1'b0;
            done           <= 1'b0;
            err_misaligned <= 1'b0;
            err_illegal    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_err_r      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= pipe_store;
                        mem_addr  <= pipe_addr;
                        mem_wdata <= pipe_wdata;
                    end else if (pipe_valid & pipe_load & pipe_store) begin
                        // Illegal takes priority over misalignment.
                        err_illegal <= 1'b1;
                    end else if (pipe_valid & one_kind & ~aligned) begin
                        err_misaligned <= 1'b1;
                    end
                end
                REQ: begin
                    // mem_we doubles as the load/store flag of the open request.
                    if (mem_ack) begin
                        state      <= DONE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        done       <= 1'b1;
                        load_valid <= ~mem_we;
                        if (!mem_we) begin
                            load_data <= mem_rdata;
                        end
                    end else if (expired) begin
                        state   <= ABORT;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                        bus_err_r <= 1'b1;
`endif
                    end
                end
                DONE:    state <= IDLE;
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_initiator.sv
// tb/tb_dmem_initiator.sv - self-checking bench for dmem_initiator
module tb_dmem_initiator;

    localparam int TO = 4;
`ifdef DMEM_TIMEOUT_EN
    localparam int STORE_WAIT = 2;
`else
    localparam int STORE_WAIT = 4;
`endif

    logic        clk;
    logic        reset;
    logic        pipe_valid, pipe_load, pipe_store;
    logic [31:0] pipe_addr, pipe_wdata;
    logic        stall, load_valid, done, err_misaligned, err_illegal, bus_err;
    logic [31:0] load_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_initiator #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_load(pipe_load), .pipe_store(pipe_store),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .done(done),
        .err_misaligned(err_misaligned), .err_illegal(err_illegal), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: an open request, a pending completion or abort
    // notice, pending reject flags, and the architectural load result.
    bit        m_open, m_open_store, m_cmp, m_cmp_load, m_abt, m_ill, m_mis;
    logic [31:0] m_addr, m_wdata, m_ld;
    int        m_wait;

    function automatic bit m_idle();
        return !m_open && !m_cmp && !m_abt;
    endfunction

    function automatic bit m_accept();
        return m_idle() && pipe_valid && (pipe_load != pipe_store) && (pipe_addr[1:0] == 2'b00);
    endfunction

    task automatic m_reset();
        m_open = 0; m_open_store = 0; m_cmp = 0; m_cmp_load = 0; m_abt = 0;
        m_ill = 0; m_mis = 0; m_addr = 0; m_wdata = 0; m_ld = 0; m_wait = 0;
    endtask

    task automatic m_step();
        bit acc, n_cmp, n_cmp_load, n_abt, idle;
        idle = m_idle();
        acc = m_accept();
        n_cmp = 0; n_cmp_load = 0; n_abt = 0;
        if (m_open) begin
            if (mem_ack) begin
                m_open = 0;
                n_cmp = 1;
                n_cmp_load = !m_open_store;
                if (!m_open_store) m_ld = mem_rdata;
            end else begin
                m_wait++;
`ifdef DMEM_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_open = 0;
                    n_abt = 1;
                end
`endif
            end
        end
        m_ill = idle && pipe_valid && pipe_load && pipe_store;
        m_mis = idle && pipe_valid && (pipe_load != pipe_store) && (pipe_addr[1:0] != 2'b00);
        if (acc) begin
            m_open = 1; m_open_store = pipe_store;
            m_addr = pipe_addr; m_wdata = pipe_wdata; m_wait = 0;
        end
        m_cmp = n_cmp; m_cmp_load = n_cmp_load; m_abt = n_abt;
    endtask

    // Compare process: every cycle, well after the input change at negedge.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            #2;
            if (!reset) m_reset();
            chk("stall",       {31'd0, stall},          {31'd0, reset && (m_open || m_accept())});
            chk("mem_req",     {31'd0, mem_req},        {31'd0, m_open});
            chk("mem_we",      {31'd0, mem_we},         {31'd0, m_open && m_open_store});
            chk("mem_addr",    mem_addr,                m_addr);
            chk("mem_wdata",   mem_wdata,               m_wdata);
            chk("load_data",   load_data,               m_ld);
            chk("load_valid",  {31'd0, load_valid},     {31'd0, m_cmp && m_cmp_load});
            chk("done",        {31'd0, done},           {31'd0, m_cmp});
            chk("err_illegal", {31'd0, err_illegal},    {31'd0, m_ill});
            chk("err_misal",   {31'd0, err_misaligned}, {31'd0, m_mis});
            chk("bus_err",     {31'd0, bus_err},        {31'd0, m_abt});
            if (reset) m_step();
        end
    end

    task automatic drv(input bit v, input bit l, input bit s, input logic [31:0] a,
                       input logic [31:0] wd, input bit ack, input logic [31:0] rd);
        @(negedge clk);
        pipe_valid = v; pipe_load = l; pipe_store = s;
        pipe_addr = a; pipe_wdata = wd; mem_ack = ack; mem_rdata = rd;
        #3;
    endtask

    initial begin
        reset = 1'b0;
        pipe_valid = 0; pipe_load = 0; pipe_store = 0;
        pipe_addr = 0; pipe_wdata = 0; mem_ack = 0; mem_rdata = 0;
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_req", {31'd0, mem_req}, 32'd0);
        chk("lit_rst_ld", load_data, 32'd0);
        @(negedge clk); reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);

        // Load 0x10, immediate ack.
        drv(1, 1, 0, 32'h10, 0, 0, 0);
        chk("lit_ld_stall_T", {31'd0, stall}, 32'd1);
        drv(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("lit_ld_req_T1", {31'd0, mem_req}, 32'd1);
        chk("lit_ld_stall_T1", {31'd0, stall}, 32'd1);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_ld_done", {31'd0, done}, 32'd1);
        chk("lit_ld_valid", {31'd0, load_valid}, 32'd1);
        chk("lit_ld_data", load_data, 32'hDEADBEEF);
        chk("lit_ld_req_T2", {31'd0, mem_req}, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_ld_done_off", {31'd0, done}, 32'd0);

        // Store 0x20 with delayed ack.
        drv(1, 0, 1, 32'h20, 32'h12345678, 0, 0);
        for (int w = 0; w <= STORE_WAIT; w++) begin
            drv(0, 0, 0, 0, 0, (w == STORE_WAIT), 32'hFFFF0000);
            chk("lit_st_req", {31'd0, mem_req}, 32'd1);
            chk("lit_st_we", {31'd0, mem_we}, 32'd1);
            chk("lit_st_addr", mem_addr, 32'h20);
            chk("lit_st_wdata", mem_wdata, 32'h12345678);
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_st_done", {31'd0, done}, 32'd1);
        chk("lit_st_lv", {31'd0, load_valid}, 32'd0);
        chk("lit_st_ld", load_data, 32'hDEADBEEF);

        // Misaligned, then illegal with misaligned address.
        drv(1, 1, 0, 32'h13, 0, 0, 0);
        chk("lit_mis_stall", {31'd0, stall}, 32'd0);
        drv(1, 1, 1, 32'h13, 0, 0, 0);
        chk("lit_mis_flag", {31'd0, err_misaligned}, 32'd1);
        chk("lit_mis_req", {31'd0, mem_req}, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_ill_flag", {31'd0, err_illegal}, 32'd1);
        chk("lit_ill_mis", {31'd0, err_misaligned}, 32'd0);

        // Back-to-back loads with zero-wait responder.
        drv(1, 1, 0, 32'h0, 0, 0, 0);
        drv(1, 1, 0, 32'h4, 0, 1, 32'h11111111);
        drv(1, 1, 0, 32'h4, 0, 0, 0);
        chk("lit_b2b_done0", {31'd0, done}, 32'd1);
        chk("lit_b2b_ld0", load_data, 32'h11111111);
        chk("lit_b2b_stall_done", {31'd0, stall}, 32'd0);
        drv(1, 1, 0, 32'h4, 0, 0, 0);
        chk("lit_b2b_acc", {31'd0, stall}, 32'd1);
        chk("lit_b2b_gap", {31'd0, done}, 32'd0);
        drv(0, 0, 0, 0, 0, 1, 32'h22222222);
        chk("lit_b2b_addr", mem_addr, 32'h4);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_b2b_done1", {31'd0, done}, 32'd1);
        chk("lit_b2b_ld1", load_data, 32'h22222222);

`ifdef DMEM_TIMEOUT_EN
        // No ack: abort after TO REQ cycles, then a normal load.
        drv(1, 1, 0, 32'h50, 0, 0, 0);
        for (int w = 0; w < TO; w++) begin
            drv(0, 0, 0, 0, 0, 0, 0);
            chk("lit_to_req", {31'd0, mem_req}, 32'd1);
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_to_buserr", {31'd0, bus_err}, 32'd1);
        chk("lit_to_req_off", {31'd0, mem_req}, 32'd0);
        chk("lit_to_done", {31'd0, done}, 32'd0);
        drv(1, 1, 0, 32'h54, 0, 0, 0);
        chk("lit_to_buserr_off", {31'd0, bus_err}, 32'd0);
        drv(0, 0, 0, 0, 0, 1, 32'hDA7A0001);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_to_after_done", {31'd0, done}, 32'd1);
        chk("lit_to_after_ld", load_data, 32'hDA7A0001);
`endif

        // Reset during REQ of a load.
        drv(1, 1, 0, 32'h40, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 32'hBAD0BAD0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("lit_rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("lit_rst_mid_done", {31'd0, done}, 32'd0);
        chk("lit_rst_mid_ld", load_data, 32'd0);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_after_done", {31'd0, done}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            int k;
            @(negedge clk);
            if (i == 400) reset = 1'b0;
            if (i == 403) reset = 1'b1;
            pipe_valid = ($urandom_range(0, 9) < 7);
            k = $urandom_range(0, 9);
            pipe_load  = (k <= 3) || (k == 8);
            pipe_store = (k >= 4 && k <= 8);
            pipe_addr  = $urandom;
            if ($urandom_range(0, 4) != 0) pipe_addr[1:0] = 2'b00;
            pipe_wdata = $urandom;
            mem_ack    = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        pipe_valid = 0; mem_ack = 0;
        repeat (3) @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_initiator.md
Name: dmem_initiator

Overview:
- Pipeline-side initiator for data-memory accesses.
- Takes one load/store per transaction from the EX/MEM boundary and drives a req/ack handshake to the data-memory responder.
- Stalls the pipeline until the responder acknowledges, then returns load data to write-back.
- Enforces word alignment and single-outstanding-request ordering.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width; sourced from mips_pkg.
- DATA, 32, data-word width; sourced from mips_pkg.
- TIMEOUT_CYCLES, 16, REQ cycles without ack before abort; only used when DMEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
- pipe_valid  input  1  EX/MEM presents a memory operation this cycle.
- pipe_load  input  1  operation is a load.
- pipe_store  input  1  operation is a store.
- pipe_addr  input  ADDRESS_WIDTH  byte address.
- pipe_wdata  input  DATA  store data.
- stall  output  1  freeze upstream pipeline.
- load_data  output  DATA  last completed load result.
- load_valid  output  1  one-cycle pulse; load_data is new.
- done  output  1  one-cycle pulse on any completed transaction.
- err_misaligned  output  1  one-cycle pulse; pipe_addr[1:0] != 0.
- err_illegal  output  1  one-cycle pulse; pipe_load and pipe_store both high.
- bus_err  output  1  one-cycle pulse on timeout abort; tied 0 when DMEM_TIMEOUT_EN is undefined.
- mem_req  output  1  request to responder.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  ADDRESS_WIDTH  request address.
- mem_wdata  output  DATA  write data.
- mem_ack  input  1  responder completes the request this cycle.
- mem_rdata  input  DATA  read data; valid when mem_ack is high.

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, load_data, load_valid, done, all error flags, timeout counter. stall is 0.
- FSM states: IDLE, REQ, DONE (+ ABORT with DMEM_TIMEOUT_EN).
- Accept rule: state IDLE, pipe_valid=1, exactly one of pipe_load/pipe_store high, pipe_addr[1:0]=0.
- On accept: latch addr/wdata/we into registered mem_* outputs; next state REQ.
- Reject, illegal: pipe_valid with load&store both high -> err_illegal pulse next cycle, no request, stay IDLE.
- Reject, misaligned: pipe_valid with misaligned address -> err_misaligned pulse next cycle, no request, stay IDLE.
- If both illegal and misaligned: only err_illegal pulses.
- pipe_valid with neither load nor store: ignored, no flags.
- REQ:
  - mem_req=1; mem_addr/mem_we/mem_wdata held stable until ack.
  - mem_ack=1 -> next DONE; if load, load_data <= mem_rdata on that edge.
  - mem_ack=0 -> stay REQ.
- DONE: done=1 for one cycle; load_valid=1 if load. mem_req=0, mem_we=0; next IDLE.
- mem_ack outside REQ is ignored.
- stall (combinational) = (state==REQ) | (state==IDLE & accept). stall is 0 in DONE, so the next operation may present in DONE and is accepted in the following IDLE cycle.
- Latency with zero-wait responder: accept at T; REQ at T+1 with ack; DONE pulse at T+2. Back-to-back throughput is one transaction per 3 cycles.
- load_data holds its value between loads; stores never modify it.
- Reset mid-transaction: mem_req drops asynchronously, no done pulse, the partial load is discarded.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - 8-bit counter, cleared on entry to REQ, increments each REQ cycle without ack.
  - Reaching TIMEOUT_CYCLES -> ABORT: mem_req=0, bus_err pulse, no done/load_valid, load_data unchanged; next IDLE.
  - Ack arriving in the same cycle the count is reached wins; the transaction completes normally.
- Undefined: no counter, REQ waits indefinitely, bus_err tied 0.

Decomposition:
- mips_pkg gains a dmem_state_t enum (IDLE, REQ, DONE, ABORT) and a TIMEOUT_CYCLES default constant.
- mips_pkg already supplies ADDRESS_WIDTH, DATA and BPI; reuse them.
- One natural sub-module, dmem_timeout_ctr (counter plus expiry compare), instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Load addr 0x0000_0010, responder acks on first REQ cycle with rdata 0xDEAD_BEEF -> mem_req high 1 cycle; load_valid and done at T+2; load_data=0xDEAD_BEEF; stall high for cycles T and T+1.
- Store addr 0x20, wdata 0x1234_5678, ack delayed 4 cycles -> mem_addr/mem_wdata/mem_we stable 5 REQ cycles; done pulses; load_valid stays 0; load_data unchanged.
- Load addr 0x13 -> err_misaligned pulse, mem_req never asserts, stall 0. Load and store both high -> err_illegal only.
- Reset driven low during REQ of a load -> mem_req low before the next clk edge; no done; load_data=0.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err pulse after 4 REQ cycles; return to IDLE; next load with immediate ack completes normally.
- Back-to-back loads 0x0, 0x4 with zero-wait responder -> done pulses 3 cycles apart; load_data updates in order.
